// File: rtl/ram_stream_reader.sv
// Read-side sequencer: issues RAM reads for a base/len window and streams the words out through a 2-entry buffer.
// Optional feature macro STREAM_STALL_CNT_EN adds the stall_cnt backpressure counter port.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef STREAM_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len_q, issued;
  logic [ADDR_WIDTH-1:0] addr_q, last_addr;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  pop, issue, accept, finish;

  assign out_valid = (buf_count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Words buffered plus in flight after this edge must stay within the 2-entry buffer.
  assign occupancy = 3'(buf_count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == RUN) && (issued < len_q) && (occupancy < 3'd2);
  assign ram_rd_en = issue;
  assign ram_addr  = issue ? addr_q : last_addr;
  assign finish    = (issued == len_q) && !inflight &&
                     ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      len_q         <= '0;
      issued        <= '0;
      addr_q        <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && (issued == len_q - CNT_ONE);
      if (accept) begin
        len_q  <= len;
        issued <= '0;
        addr_q <= base_addr;
      end else if (issue) begin
        issued    <= issued + CNT_ONE;
        last_addr <= addr_q;
        addr_q    <= (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_ONE;
      end
    end
  end

  // RAM data lands one edge after its issue cycle; buffer is a 2-deep circular FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_count   <= '0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= ram_dout;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + 2'(inflight) - 2'(pop);
    end
  end

`ifdef STREAM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: behavioural RAM plus an address-order reference of the stream.
// Honours STREAM_STALL_CNT_EN to connect and check stall_cnt.
module tb_ram_stream_reader;

  localparam int AW    = 12;
  localparam int DW    = 64;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_rd_en, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] out_data;
`ifdef STREAM_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  logic [DW-1:0] ram [DEPTH];
  int checks = 0;
  int errors = 0;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready)
`ifdef STREAM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one cycle of read latency.
  always @(posedge clk) if (ram_rd_en) ram_dout <= ram[ram_addr[7:0]];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_rd_en"}, 64'(ram_rd_en), 64'(0));
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(0));
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  task automatic applyStimulus(input int base, input int n, input int mode, input bit restart);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            prev_stall, finished;
    int            cyc, got, issued, stalls;
    for (int k = 0; k < n; k++) exp_q.push_back(ram[(base + k) % DEPTH]);
    prev_data = '0; prev_last = 1'b0; prev_stall = 1'b0; finished = 1'b0;
    cyc = 0; got = 0; issued = 0; stalls = 0;
    @(posedge clk); #1;
    base_addr = AW'(base); len = (AW+1)'(n); start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 4 * n + 40) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (restart && cyc == 4) begin
        start = 1'b1; base_addr = AW'((base + 77) % DEPTH); len = (AW+1)'(3);
      end
      @(negedge clk);
      checkOutput("busy", 64'(busy), 64'(1));
      if (ram_rd_en) begin
        checkOutput("ram_addr", 64'(ram_addr), 64'((base + issued) % DEPTH));
        issued++;
      end
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1));
        checkOutput("hold_data", out_data, prev_data);
        checkOutput("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (mode == 0 && n > 0)
        checkOutput("valid_timing", 64'(out_valid), 64'(cyc >= 2 && cyc < n + 2));
      if (out_valid) begin
        checkOutput("no_extra_word", 64'(got < n), 64'(1));
        if (got < n) begin
          checkOutput("out_data", out_data, exp_q[got]);
          checkOutput("out_last", 64'(out_last), 64'(got == n - 1));
        end
        if (out_ready) got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (prev_stall) stalls++;
      checkOutput("occupancy", 64'((issued - got) <= 2), 64'(1));
      if (done) begin
        finished = 1'b1;
        checkOutput("done_words", 64'(got), 64'(n));
        checkOutput("done_issued", 64'(issued), 64'(n));
        if (mode == 0) checkOutput("done_timing", 64'(cyc), 64'((n == 0) ? 0 : n + 2));
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    checkOutput("timeout", 64'(finished), 64'(1));
    @(negedge clk);
    checkIdleOutputs("after_done");
`ifdef STREAM_STALL_CNT_EN
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  task automatic abortRun();
    int got, cyc;
    got = 0; cyc = 0;
    @(posedge clk); #1;
    base_addr = AW'(40); len = (AW+1)'(16); start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checkOutput("abort_data", out_data, ram[(40 + got) % DEPTH]);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("abort_reach_word3", 64'(got), 64'(4));
    rstn = 1'b0;
    #1;
    checkIdleOutputs("abort");
    checkOutput("abort_addr", 64'(ram_addr), 64'(0));
    checkOutput("abort_out_data", out_data, 64'(0));
    checkOutput("abort_last", 64'(out_last), 64'(0));
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", 64'(done), 64'(0));
    end
    rstn = 1'b1;
    applyStimulus(0, 4, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, 32'(i)};
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_addr", 64'(ram_addr), 64'(0));
    checkOutput("reset_data", out_data, 64'(0));
    checkOutput("reset_last", 64'(out_last), 64'(0));
`ifdef STREAM_STALL_CNT_EN
    checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    rstn = 1'b1;
    $display("[TB] basic, wrap, backpressure, empty, restart, abort");
    applyStimulus(0, 8, 0, 1'b0);
    applyStimulus(250, 10, 0, 1'b0);
    applyStimulus(int'($urandom_range(0, DEPTH - 1)), 16, 1, 1'b0);
    applyStimulus(17, 0, 0, 1'b0);
    applyStimulus(20, 12, 0, 1'b1);
    abortRun();
    $display("[TB] randomized transfers");
    for (int t = 0; t < 6; t++)
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
    applyStimulus(200, DEPTH, 2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
